mem_wait_ctrl: RTL and testbench
================================

Name: mem_wait_ctrl

Overview:
- Sequences the MEM stage and the MEM/WB pipeline register around a variable-latency data memory using a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding, and injects bubbles into MEM/WB until the access completes.
- Squashes accesses that exceed a timeout and raises a fault pulse.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- TIMEOUT, 16: max WAIT cycles before the access is abandoned (>=2).
- CNT_W, 32: width of stall_cycles counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- MemReadM  input  1  load present in MEM stage.
- MemWriteM  input  1  store present in MEM stage.
- mem_ack  input  1  data memory completes the current request this cycle.
- mem_req  output  1  request to data memory, held until ack.
- mem_we  output  1  write enable to data memory (= MemWriteM while mem_req).
- StallM  output  1  freeze PC, IF/ID, ID/EX, EX/MEM registers.
- FlushW  output  1  MEM/WB loads a bubble (rdW=0, no write) this edge.
- mem_fault  output  1  one-cycle pulse when an access times out.
- busy  output  1  state != IDLE.
- stall_cycles  output  CNT_W  number of cycles StallM was 1, saturating.

Behaviour:
- States: IDLE, WAIT, ERR. Single registered state; wait_cnt counts cycles spent in WAIT.
- access = MemReadM | MemWriteM.
- Reset: the edge with rst=1 leaves state=IDLE, wait_cnt=0, stall_cycles=0.
  - While rst=1, all outputs are driven 0 regardless of other inputs.
  - Reset mid-WAIT abandons the access without a fault pulse.
- IDLE:
  - mem_req=access, mem_we=MemWriteM, mem_fault=0.
  - access & mem_ack: zero-wait access. StallM=0, FlushW=0, stay IDLE.
  - access & !mem_ack: StallM=1, FlushW=1, next state WAIT, wait_cnt<=0.
  - !access: all outputs 0. mem_ack is ignored.
- WAIT:
  - mem_req=1 held, mem_we=MemWriteM. MemReadM/MemWriteM are stable because the pipeline is frozen.
  - mem_ack=1: StallM=0, FlushW=0 (MEM/WB captures the real result this edge), next state IDLE.
  - mem_ack=0 & wait_cnt<TIMEOUT-1: StallM=1, FlushW=1, wait_cnt++.
  - mem_ack=0 & wait_cnt==TIMEOUT-1: StallM=1, FlushW=1, next state ERR.
- ERR (one cycle):
  - mem_req=0, mem_fault=1, StallM=0, FlushW=1: the faulting instruction advances as a bubble.
  - Next state IDLE. A mem_ack arriving in ERR is ignored.
- Completion precedence: mem_ack in the final WAIT cycle (wait_cnt==TIMEOUT-1) wins over timeout, so the access completes normally.
- Back-to-back accesses: after a WAIT->IDLE completion the next instruction enters MEM and is evaluated in IDLE on the following cycle. There is no dead cycle.
- Latency: a k-wait access (ack in the k-th WAIT cycle, k>=1) gives k cycles of StallM=1 total, counting the IDLE entry cycle.
- stall_cycles: increments on every edge where StallM=1 and rst=0; saturates at all-ones.
- busy = (state != IDLE).
- StallM, FlushW, mem_req, mem_we and mem_fault are combinational from state, wait_cnt and the inputs, with no path from mem_ack to state in the same cycle.

Test Plan:
- Zero-wait load: MemReadM=1 and mem_ack=1 in cycle 0 -> mem_req=1, StallM=0, FlushW=0, state stays IDLE, stall_cycles=0.
- 3-cycle store: MemWriteM=1, mem_ack asserted in 3rd cycle after entry ->
  - StallM=1 and FlushW=1 in cycles 0-2, mem_we=1 throughout.
  - In the ack cycle StallM=0; stall_cycles=3.
- Timeout with TIMEOUT=4: MemReadM=1, mem_ack never asserted ->
  - StallM=1 for 5 cycles (IDLE entry + 4 WAIT), then ERR: mem_fault=1, FlushW=1, StallM=0, mem_req=0.
  - Back to IDLE next cycle.
- Ack on timeout boundary: mem_ack=1 exactly when wait_cnt==TIMEOUT-1 -> normal completion, mem_fault stays 0, no ERR.
- Reset mid-WAIT: rst=1 two cycles into WAIT ->
  - Next cycle state IDLE, all outputs 0, stall_cycles=0, no mem_fault.
- Spurious ack and back-to-back:
  - mem_ack=1 with access=0 -> no effect.
  - Two loads in consecutive instructions, each acked after 1 wait -> StallM pattern 1,0,1,0; no extra bubble.

Source files
------------

// File: rtl/mem_wait_ctrl_if.sv
// mem_wait_ctrl_if
//   Bundles the MEM-stage / data-memory handshake and the pipeline control
//   outputs of mem_wait_ctrl.
//   slave  : the controller (takes MemReadM/MemWriteM/mem_ack, drives the rest)
//   master : the environment (pipeline + data memory)
//   Signals:
//     MemReadM, MemWriteM  load/store present in MEM
//     mem_ack              memory completes the current request this cycle
//     mem_req, mem_we      request / write enable to data memory
//     StallM               freeze upstream pipeline registers
//     FlushW               MEM/WB loads a bubble this edge
//     mem_fault            one-cycle timeout pulse
//     busy                 controller not idle
//     stall_cycles         saturating count of StallM cycles
interface mem_wait_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             MemReadM;
  logic             MemWriteM;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             StallM;
  logic             FlushW;
  logic             mem_fault;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  MemReadM, MemWriteM, mem_ack,
    output mem_req, mem_we, StallM, FlushW, mem_fault, busy, stall_cycles
  );

  modport master (
    output MemReadM, MemWriteM, mem_ack,
    input  mem_req, mem_we, StallM, FlushW, mem_fault, busy, stall_cycles
  );
endinterface

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl
//   Sequences the MEM stage and MEM/WB register around a variable-latency
//   data memory. While a request is outstanding the upstream pipeline is
//   frozen (StallM) and MEM/WB takes bubbles (FlushW). An access that sees no
//   ack within TIMEOUT wait cycles is abandoned: one ERR cycle pulses
//   mem_fault and lets the faulting instruction drain as a bubble.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset; forces every output to 0 while high
//     bus  mem_wait_ctrl_if.slave (handshake, pipeline control, perf counter)
//   Parameters:
//     TIMEOUT  max WAIT cycles before abandoning the access (>= 2)
//     CNT_W    width of the stall-cycle counter
module mem_wait_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_wait_ctrl_if.slave   bus
);

  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t           state;
  logic [WC_W-1:0]  wait_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic access;
  logic req, we, stall, flush, fault;

  assign access = bus.MemReadM | bus.MemWriteM;

  // Outputs depend on current state and inputs only; mem_ack reaches the
  // state register solely through the next edge.
  always_comb begin
    req   = 1'b0;
    we    = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    fault = 1'b0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          // Without an access the bus is quiet and any ack is spurious.
          if (access) begin
            req   = 1'b1;
            we    = bus.MemWriteM;
            stall = ~bus.mem_ack;
            flush = ~bus.mem_ack;
          end
        end
        S_WAIT: begin
          // Ack wins even on the last wait cycle, so completion beats timeout.
          req   = 1'b1;
          we    = bus.MemWriteM;
          stall = ~bus.mem_ack;
          flush = ~bus.mem_ack;
        end
        S_ERR: begin
          // Release the pipeline but keep the squashed instruction out of WB.
          flush = 1'b1;
          fault = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      unique case (state)
        S_IDLE: begin
          if (access && !bus.mem_ack) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (bus.mem_ack)
            state <= S_IDLE;
          else if (wait_cnt == WC_LAST)
            state <= S_ERR;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req      = req;
  assign bus.mem_we       = we;
  assign bus.StallM       = stall;
  assign bus.FlushW       = flush;
  assign bus.mem_fault    = fault;
  assign bus.busy         = ~rst & (state != S_IDLE);
  assign bus.stall_cycles = rst ? '0 : stall_cnt;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
module tb_mem_wait_ctrl;
  localparam int TO = 4;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  mem_wait_ctrl_if #(.CNT_W(CW)) bus ();

  mem_wait_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, StallM, FlushW, mem_fault, busy}
  logic [5:0] o;
  always_comb o = {bus.mem_req, bus.mem_we, bus.StallM, bus.FlushW, bus.mem_fault, bus.busy};

  task automatic drive(input logic rd, input logic wr, input logic ack);
    bus.MemReadM  = rd;
    bus.MemWriteM = wr;
    bus.mem_ack   = ack;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(0, 0, 0);
    next_cycle();
    rst = 1'b0; exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive(1, 1, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (o !== 6'b000000) begin errors++; $display("FAIL reset_outs: got %b want %b", o, 6'b000000); end
      checks++; if (bus.stall_cycles !== CW'(0)) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cycles); end
      next_cycle();
    end
    rst = 1'b0; drive(0, 0, 0); exp_cnt = 0;
    @(negedge clk);
    checks++; if (o !== 6'b000000) begin errors++; $display("FAIL reset_idle: got %b want %b", o, 6'b000000); end
    checks++; if (bus.stall_cycles !== CW'(0)) begin errors++; $display("FAIL reset_idle_cnt: got %0d want 0", bus.stall_cycles); end
    next_cycle();
  endtask

  task automatic test_zero_wait();
    do_reset();
    drive(1, 0, 1); @(negedge clk);
    checks++; if (o !== 6'b100000) begin errors++; $display("FAIL zero_wait: got %b want %b", o, 6'b100000); end
    next_cycle();
    drive(0, 0, 0); @(negedge clk);
    checks++; if (o !== 6'b000000) begin errors++; $display("FAIL zero_wait_after: got %b want %b", o, 6'b000000); end
    checks++; if (bus.stall_cycles !== CW'(0)) begin errors++; $display("FAIL zero_wait_cnt: got %0d want 0", bus.stall_cycles); end
    next_cycle();
  endtask

  task automatic test_store3();
    do_reset();
    drive(0, 1, 0); @(negedge clk);
    checks++; if (o !== 6'b111100) begin errors++; $display("FAIL store3_c0: got %b want %b", o, 6'b111100); end
    next_cycle();
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++; if (o !== 6'b111101) begin errors++; $display("FAIL store3_c%0d: got %b want %b", i, o, 6'b111101); end
      next_cycle();
    end
    drive(0, 1, 1); @(negedge clk);
    checks++; if (o !== 6'b110001) begin errors++; $display("FAIL store3_ack: got %b want %b", o, 6'b110001); end
    next_cycle();
    drive(0, 0, 0); @(negedge clk);
    checks++; if (o !== 6'b000000) begin errors++; $display("FAIL store3_idle: got %b want %b", o, 6'b000000); end
    checks++; if (bus.stall_cycles !== CW'(3)) begin errors++; $display("FAIL store3_cnt: got %0d want 3", bus.stall_cycles); end
    next_cycle();
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1, 0, 0); @(negedge clk);
    checks++; if (o !== 6'b101100) begin errors++; $display("FAIL timeout_c0: got %b want %b", o, 6'b101100); end
    next_cycle();
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      checks++; if (o !== 6'b101101) begin errors++; $display("FAIL timeout_c%0d: got %b want %b", i, o, 6'b101101); end
      next_cycle();
    end
    drive(1, 0, 1); @(negedge clk);  // late ack in ERR must be ignored
    checks++; if (o !== 6'b000111) begin errors++; $display("FAIL timeout_err: got %b want %b", o, 6'b000111); end
    next_cycle();
    drive(0, 0, 0); @(negedge clk);
    checks++; if (o !== 6'b000000) begin errors++; $display("FAIL timeout_idle: got %b want %b", o, 6'b000000); end
    checks++; if (bus.stall_cycles !== CW'(TO + 1)) begin errors++; $display("FAIL timeout_cnt: got %0d want %0d", bus.stall_cycles, TO + 1); end
    next_cycle();
  endtask

  task automatic test_ack_boundary();
    do_reset();
    drive(1, 0, 0); @(negedge clk);
    checks++; if (o !== 6'b101100) begin errors++; $display("FAIL bound_c0: got %b want %b", o, 6'b101100); end
    next_cycle();
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      checks++; if (o !== 6'b101101) begin errors++; $display("FAIL bound_c%0d: got %b want %b", i, o, 6'b101101); end
      next_cycle();
    end
    drive(1, 0, 1); @(negedge clk);
    checks++; if (o !== 6'b100001) begin errors++; $display("FAIL bound_ack: got %b want %b", o, 6'b100001); end
    next_cycle();
    drive(0, 0, 0); @(negedge clk);
    checks++; if (o !== 6'b000000) begin errors++; $display("FAIL bound_noerr: got %b want %b", o, 6'b000000); end
    checks++; if (bus.stall_cycles !== CW'(TO)) begin errors++; $display("FAIL bound_cnt: got %0d want %0d", bus.stall_cycles, TO); end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(0, 1, 0); @(negedge clk);
    checks++; if (o !== 6'b111100) begin errors++; $display("FAIL rstmid_c0: got %b want %b", o, 6'b111100); end
    next_cycle();
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++; if (o !== 6'b111101) begin errors++; $display("FAIL rstmid_c%0d: got %b want %b", i, o, 6'b111101); end
      next_cycle();
    end
    rst = 1'b1; @(negedge clk);
    checks++; if (o !== 6'b000000) begin errors++; $display("FAIL rstmid_during: got %b want %b", o, 6'b000000); end
    next_cycle();
    rst = 1'b0; drive(0, 0, 0); exp_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (o !== 6'b000000) begin errors++; $display("FAIL rstmid_after%0d: got %b want %b", i, o, 6'b000000); end
      checks++; if (bus.stall_cycles !== CW'(0)) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", bus.stall_cycles); end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_seq [4] = '{6'b101100, 6'b100001, 6'b101100, 6'b100001};
    logic       ack_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1); @(negedge clk);
      checks++; if (o !== 6'b000000) begin errors++; $display("FAIL spurious%0d: got %b want %b", i, o, 6'b000000); end
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, ack_seq[i]); @(negedge clk);
      checks++; if (o !== exp_seq[i]) begin errors++; $display("FAIL b2b_c%0d: got %b want %b", i, o, exp_seq[i]); end
      next_cycle();
    end
    drive(0, 0, 0); @(negedge clk);
    checks++; if (bus.stall_cycles !== CW'(2)) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", bus.stall_cycles); end
    next_cycle();
  endtask

  // Transaction-level model: each instruction is an idle gap or an access
  // with an ack delay k; k==0 is zero-wait, k<=TO completes after k stall
  // cycles, k>TO times out after TO+1 stall cycles plus one ERR cycle.
  task automatic test_random();
    do_reset();
    for (int t = 0; t < 200; t++) begin
      int kind, k, ncyc;
      logic rd, wr;
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        ncyc = int'($urandom_range(1, 2));
        for (int j = 0; j < ncyc; j++) begin
          drive(0, 0, 1'($urandom)); @(negedge clk);
          checks++; if (o !== 6'b000000) begin errors++; $display("FAIL rnd_idle t%0d: got %b want %b", t, o, 6'b000000); end
          checks++; if (bus.stall_cycles !== CW'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt t%0d: got %0d want %0d", t, bus.stall_cycles, exp_cnt); end
          next_cycle();
        end
      end else begin
        rd = (kind != 2);
        wr = (kind != 1);
        k  = int'($urandom_range(0, TO + 2));
        ncyc = (k > TO) ? TO + 2 : k + 1;
        for (int j = 0; j < ncyc; j++) begin
          logic [5:0] e;
          logic st, ack;
          if (k > TO && j == TO + 1) begin
            e = 6'b000111; st = 1'b0; ack = 1'($urandom);
          end else if (k <= TO && j == k) begin
            e = {1'b1, wr, 2'b00, 1'b0, (j > 0)}; st = 1'b0; ack = 1'b1;
          end else begin
            e = {1'b1, wr, 2'b11, 1'b0, (j > 0)}; st = 1'b1; ack = 1'b0;
          end
          drive(rd, wr, ack); @(negedge clk);
          checks++; if (o !== e) begin errors++; $display("FAIL rnd_out t%0d k%0d j%0d: got %b want %b", t, k, j, o, e); end
          checks++; if (bus.stall_cycles !== CW'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt t%0d: got %0d want %0d", t, bus.stall_cycles, exp_cnt); end
          next_cycle();
          if (st && exp_cnt < CMAX) exp_cnt++;
        end
      end
    end
    drive(0, 0, 0); @(negedge clk);
    checks++; if (bus.stall_cycles !== CW'(exp_cnt)) begin errors++; $display("FAIL rnd_final_cnt: got %0d want %0d", bus.stall_cycles, exp_cnt); end
    next_cycle();
  endtask

  initial begin
    drive(0, 0, 0);
    test_reset();
    test_zero_wait();
    test_store3();
    test_timeout();
    test_ack_boundary();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
